// File: rtl/pe_array_scheduler.sv
// Sequences an N x N systolic MAC array through one product C = A(NxK) x B(KxN):
// per-step operand fetch, skewed wavefront enables, then a wait for every enabled PE.
module pe_array_scheduler #(
    parameter int unsigned N       = 4,
    parameter int unsigned K_MAX   = 16,
    parameter int unsigned KW      = $clog2(K_MAX + 1),
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            abort,
    output logic            op_rd_en,
    output logic [KW-1:0]   op_rd_k,
    input  logic            op_rd_valid,
    output logic            acc_clr,
    output logic [N*N-1:0]  pe_en,
    input  logic [N*N-1:0]  pe_ready,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [KW+3:0]   step
);

    localparam int unsigned NN    = N * N;
    localparam int unsigned SW    = KW + 4;
    localparam int unsigned CW    = $clog2(TIMEOUT + 1);
    localparam int unsigned DRAIN = 2 * N - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FWAIT,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [KW-1:0]   r_k_len;
    logic [NN-1:0]   r_mask;
    logic [CW-1:0]   r_cnt;

    logic [NN-1:0]   w_mask;
    logic [SW-1:0]   w_s_total;
    logic [SW-1:0]   w_step_nxt;
    logic            w_k_ok;
    logic            w_fetch;
    logic            w_all_ready;
    logic            w_timeout;

    // Wavefront: PE(i,j) is active while step-(i+j) lies in [0, k_len)
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < int'(N); i++) begin
            for (int j = 0; j < int'(N); j++) begin
                if ((int'(step) >= i + j) && (int'(step) - (i + j) < int'(r_k_len))) begin
                    w_mask[i * int'(N) + j] = 1'b1;
                end
            end
        end
    end

    assign w_s_total   = SW'(r_k_len) + SW'(DRAIN);
    assign w_step_nxt  = step + SW'(1);
    assign w_k_ok      = (k_len != '0) && (k_len <= KW'(K_MAX));
    assign w_fetch     = step < SW'(r_k_len);
    assign w_all_ready = (pe_ready & r_mask) == r_mask;
    assign w_timeout   = r_cnt == CW'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_k_len  <= '0;
            r_mask   <= '0;
            r_cnt    <= '0;
            op_rd_en <= 1'b0;
            op_rd_k  <= '0;
            acc_clr  <= 1'b0;
            pe_en    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            step     <= '0;
        end else begin
            op_rd_en <= 1'b0;
            acc_clr  <= 1'b0;
            pe_en    <= '0;
            done     <= 1'b0;
            error    <= 1'b0;

            if (abort) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (!w_k_ok) begin
                                error <= 1'b1;
                            end else begin
                                r_k_len <= k_len;
                                step    <= '0;
                                acc_clr <= 1'b1;
                                busy    <= 1'b1;
                                r_state <= S_FETCH;
                            end
                        end
                    end
                    // Drain steps (step >= k_len) skip the fetch entirely
                    S_FETCH: begin
                        if (w_fetch) begin
                            op_rd_en <= 1'b1;
                            op_rd_k  <= KW'(step);
                            r_state  <= S_FWAIT;
                        end else begin
                            pe_en   <= w_mask;
                            r_mask  <= w_mask;
                            r_state <= S_ISSUE;
                        end
                    end
                    S_FWAIT: begin
                        if (op_rd_valid) begin
                            pe_en   <= w_mask;
                            r_mask  <= w_mask;
                            r_state <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                    // Completion wins over a timeout landing in the same cycle
                    S_WAIT: begin
                        if (w_all_ready) begin
                            step <= w_step_nxt;
                            if (w_step_nxt == w_s_total) begin
                                done    <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_FETCH;
                            end
                        end else if (w_timeout) begin
                            error   <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_DONE: begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pe_array_scheduler.sv
// Scoreboard bench for pe_array_scheduler: stimulus queues expected output events,
// a negedge monitor pops and compares each event the DUT presents.
module tb_pe_array_scheduler;

    localparam int unsigned N       = 4;
    localparam int unsigned K_MAX   = 16;
    localparam int unsigned KW      = 5;
    localparam int unsigned TIMEOUT = 255;
    localparam int unsigned NN      = N * N;

    localparam int K_ACC  = 0;
    localparam int K_RD   = 1;
    localparam int K_PE   = 2;
    localparam int K_DONE = 3;
    localparam int K_ERR  = 4;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          off;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [KW-1:0]   k_len = '0;
    logic            abort = 1'b0;
    logic            op_rd_en;
    logic [KW-1:0]   op_rd_k;
    logic            op_rd_valid;
    logic            acc_clr;
    logic [NN-1:0]   pe_en;
    logic [NN-1:0]   pe_ready = '0;
    logic            busy;
    logic            done;
    logic            error;
    logic [KW+3:0]   step;

    int              cyc = 0;
    int              t0 = 0;
    int              lat = 1;
    int              bcnt = 0;
    logic [NN-1:0]   stall = '0;
    int              n_checks = 0;
    int              n_pass = 0;
    ev_t             q[$];
    string           kname[5] = '{"acc_clr", "op_rd", "pe_en", "done", "error"};

    // Hand-computed wavefront masks for k_len=3, steps 0..8
    logic [NN-1:0]   k3_pe[9] = '{16'h0001, 16'h0013, 16'h0137, 16'h137E, 16'h37EC,
                                  16'h7EC8, 16'hEC80, 16'hC800, 16'h8000};

    pe_array_scheduler #(
        .N(N), .K_MAX(K_MAX), .KW(KW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .abort(abort),
        .op_rd_en(op_rd_en), .op_rd_k(op_rd_k), .op_rd_valid(op_rd_valid),
        .acc_clr(acc_clr), .pe_en(pe_en), .pe_ready(pe_ready), .busy(busy),
        .done(done), .error(error), .step(step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Operand buffer answers lat cycles after the request; PEs answer one cycle after enable
    always @(posedge clk) begin
        if (op_rd_en) bcnt <= lat;
        else if (bcnt != 0) bcnt <= bcnt - 1;
        pe_ready <= pe_en & ~stall;
    end
    assign op_rd_valid = (bcnt == 1);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic observe(input int kind, input logic [31:0] data);
        ev_t e;
        n_checks++;
        if (q.size() == 0) begin
            $display("FAIL unexpected_%s: got 0x%0h at offset %0d, expected no event",
                     kname[kind], data, cyc - t0);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.data !== data || (e.off >= 0 && cyc - t0 != e.off))
                $display("FAIL event: got %s 0x%0h @%0d expected %s 0x%0h @%0d",
                         kname[kind], data, cyc - t0, kname[e.kind], e.data, e.off);
            else n_pass++;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (acc_clr)       observe(K_ACC, 32'd0);
            if (op_rd_en)      observe(K_RD, 32'(op_rd_k));
            if (pe_en != '0)   observe(K_PE, 32'(pe_en));
            if (done)          observe(K_DONE, 32'd0);
            if (error)         observe(K_ERR, 32'd0);
            if (done && error) begin
                n_checks++;
                $display("FAIL done_error_overlap: got done=1 error=1 expected not both");
            end
        end
    end

    function automatic logic [NN-1:0] mask_of(input int s, input int k);
        logic [NN-1:0] m = '0;
        for (int i = 0; i < int'(N); i++)
            for (int j = 0; j < int'(N); j++)
                if (s - (i + j) >= 0 && s - (i + j) < k) m[i * int'(N) + j] = 1'b1;
        return m;
    endfunction

    task automatic push(input int kind, input logic [31:0] d, input int off);
        ev_t e;
        e.kind = kind;
        e.data = d;
        e.off  = off;
        q.push_back(e);
    endtask

    task automatic push_job(input int k, input int l, input int done_off);
        logic [NN-1:0] m;
        push(K_ACC, 32'd0, 0);
        for (int s = 0; s < k + 2 * int'(N) - 2; s++) begin
            if (s < k) push(K_RD, 32'(s), (s == 0) ? 1 : -1);
            m = (k == 3) ? k3_pe[s] : mask_of(s, k);
            push(K_PE, 32'(m), (s == 0) ? l + 2 : -1);
        end
        push(K_DONE, 32'd0, done_off);
    endtask

    task automatic start_job(input int k, input int l);
        @(negedge clk);
        lat   = l;
        k_len = KW'(k);
        start = 1'b1;
        t0    = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_op_rd_en"}, 32'(op_rd_en), 32'd0);
        chk({tag, "_op_rd_k"},  32'(op_rd_k),  32'd0);
        chk({tag, "_acc_clr"},  32'(acc_clr),  32'd0);
        chk({tag, "_pe_en"},    32'(pe_en),    32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_error"},    32'(error),    32'd0);
        chk({tag, "_step"},     32'(step),     32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        // Nominal job: k_len=3, 9 steps, done 33 cycles after start
        push_job(3, 1, 33);
        start_job(3, 1);
        repeat (40) @(negedge clk);
        chk("nominal_drained", 32'(q.size()), 32'd0);
        chk("nominal_idle_busy", 32'(busy), 32'd0);

        // Illegal k_len: error the cycle after start, never busy
        push(K_ERR, 32'd0, 0);
        start_job(0, 1);
        chk("k0_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        push(K_ERR, 32'd0, 0);
        start_job(int'(K_MAX) + 1, 1);
        chk("kmax1_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("illegal_drained", 32'(q.size()), 32'd0);

        // PE(0,0) stuck: error at the end of WAIT cycle 255, no done
        stall = 16'h0001;
        push(K_ACC, 32'd0, 0);
        push(K_RD, 32'd0, 1);
        push(K_PE, 32'h0001, 3);
        push(K_ERR, 32'd0, 259);
        start_job(3, 1);
        repeat (300) @(negedge clk);
        chk("timeout_busy", 32'(busy), 32'd0);
        stall = '0;
        repeat (5) @(negedge clk);
        chk("timeout_drained", 32'(q.size()), 32'd0);

        // Slow buffer: k_len=1, latency 5, S_total=7
        push_job(1, 5, 27);
        start_job(1, 5);
        repeat (35) @(negedge clk);
        chk("slowbuf_drained", 32'(q.size()), 32'd0);

        // Abort while waiting for the operand buffer
        push(K_ACC, 32'd0, 0);
        push(K_RD, 32'd0, 1);
        start_job(3, 5);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_fwait_busy", 32'(busy), 32'd0);
        chk("abort_fwait_pe_en", 32'(pe_en), 32'd0);
        repeat (10) @(negedge clk);
        chk("abort_fwait_drained", 32'(q.size()), 32'd0);

        // Abort while waiting on the PEs, then a clean k_len=2 job
        stall = '1;
        push(K_ACC, 32'd0, 0);
        push(K_RD, 32'd0, 1);
        push(K_PE, 32'h0001, 3);
        start_job(3, 1);
        repeat (8) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_wait_busy", 32'(busy), 32'd0);
        chk("abort_wait_pe_en", 32'(pe_en), 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_wait_drained", 32'(q.size()), 32'd0);
        stall = '0;
        push_job(2, 1, 28);
        start_job(2, 1);
        repeat (35) @(negedge clk);
        chk("rerun_drained", 32'(q.size()), 32'd0);

        // Asynchronous reset mid-WAIT clears outputs without a clock edge
        stall = '1;
        push(K_ACC, 32'd0, 0);
        push(K_RD, 32'd0, 1);
        push(K_PE, 32'h0001, 3);
        start_job(3, 1);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        stall = '0;
        chk("async_rst_drained", 32'(q.size()), 32'd0);

        // start held high while busy: exactly one job, one done
        push_job(3, 1, 33);
        @(negedge clk);
        lat   = 1;
        k_len = KW'(3);
        start = 1'b1;
        t0    = cyc + 1;
        repeat (30) @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("held_start_drained", 32'(q.size()), 32'd0);
        chk("held_start_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
